// File: rtl/alu_pipe_issuer.sv
// Issues operand pairs into a fixed-latency non-stalling ALU pipe and
// buffers returning results in an in-order FIFO with credit-based issue.
module alu_pipe_issuer #(
    parameter int DWIDTH  = 8,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DWIDTH-1:0] req_op1_i,
    input  logic [DWIDTH-1:0] req_op2_i,
    output logic [DWIDTH-1:0] pipe_op1_o,
    output logic [DWIDTH-1:0] pipe_op2_o,
    output logic              pipe_valid_o,
    input  logic [DWIDTH-1:0] pipe_res_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_res_o,
    output logic              busy_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] vld_sr;
    logic [LATENCY-1:0] vld_sr_nxt;
    logic [DWIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [31:0]        inflight;
    logic               accept;
    logic               capture;
    logic               pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 32'(vld_sr[i]);
        end
    end

    // Credit ignores a same-cycle pop so ready never depends on rsp_ready_i.
    assign req_ready_o = (32'(count) + inflight) < 32'(DEPTH);
    assign accept      = req_valid_i && req_ready_o;
    assign capture     = vld_sr[LATENCY-1];
    assign rsp_valid_o = (count != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_res_o   = rsp_valid_o ? mem[rd_ptr] : '0;
    assign busy_o      = (vld_sr != '0) || rsp_valid_o;

    always_comb begin
        vld_sr_nxt    = vld_sr << 1;
        vld_sr_nxt[0] = accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr       <= '0;
            pipe_op1_o   <= '0;
            pipe_op2_o   <= '0;
            pipe_valid_o <= 1'b0;
        end else begin
            vld_sr       <= vld_sr_nxt;
            pipe_valid_o <= accept;
            if (accept) begin
                pipe_op1_o <= req_op1_i;
                pipe_op2_o <= req_op2_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= pipe_res_i;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(capture && (count == CW'(DEPTH)))
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(pop && (count == '0))
    );

endmodule

// File: tb/tb_alu_pipe_issuer.sv
// Directed bench for alu_pipe_issuer with a 3-edge add pipe model.
module tb_alu_pipe_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_op1;
    logic [7:0] req_op2;
    logic [7:0] pipe_op1;
    logic [7:0] pipe_op2;
    logic       pipe_valid;
    logic [7:0] pipe_res;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_res;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_pipe_issuer #(.DWIDTH(8), .LATENCY(3), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op1_i    (req_op1),
        .req_op2_i    (req_op2),
        .pipe_op1_o   (pipe_op1),
        .pipe_op2_o   (pipe_op2),
        .pipe_valid_o (pipe_valid),
        .pipe_res_i   (pipe_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_res_o    (rsp_res),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] sh0;
    logic [7:0] sh1;
    always @(posedge clk) begin
        sh0 <= pipe_op1 + pipe_op2;
        sh1 <= sh0;
    end
    assign pipe_res = sh1;

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL reset_pipe_valid got %0b exp 0", pipe_valid); end
        checks++; if (pipe_op1 !== 8'd0) begin errors++; $display("FAIL reset_pipe_op1 got %0d exp 0", pipe_op1); end
        checks++; if (pipe_op2 !== 8'd0) begin errors++; $display("FAIL reset_pipe_op2 got %0d exp 0", pipe_op2); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
        checks++; if (rsp_res !== 8'd0) begin errors++; $display("FAIL reset_rsp_res got %0d exp 0", rsp_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b0; req_valid = 1'b1; req_op1 = 8'd5; req_op2 = 8'd7;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; req_op1 = 8'd0; req_op2 = 8'd0;
        checks++; if (pipe_valid !== 1'b1) begin errors++; $display("FAIL single_pipe_valid got %0b exp 1", pipe_valid); end
        checks++; if (pipe_op1 !== 8'd5) begin errors++; $display("FAIL single_pipe_op1 got %0d exp 5", pipe_op1); end
        checks++; if (pipe_op2 !== 8'd7) begin errors++; $display("FAIL single_pipe_op2 got %0d exp 7", pipe_op2); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
        @(negedge clk);
        checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL single_strobe_len got %0b exp 0", pipe_valid); end
        checks++; if (pipe_op1 !== 8'd5) begin errors++; $display("FAIL single_op_hold got %0d exp 5", pipe_op1); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got %0b exp 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early2 got %0b exp 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0b exp 1", rsp_valid); end
        checks++; if (rsp_res !== 8'd12) begin errors++; $display("FAIL single_rsp_res got %0d exp 12", rsp_res); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_res !== 8'd12) begin
            errors++; $display("FAIL single_hold got %0b/%0d exp 1/12", rsp_valid, rsp_res);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b exp 0", rsp_valid); end
        checks++; if (rsp_res !== 8'd0) begin errors++; $display("FAIL single_empty_res got %0d exp 0", rsp_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %0b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcv = 0;
        int first = -1;
        int last = -1;
        bit drop = 1'b0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && rcv < 16; cyc++) begin
            if (rsp_valid) begin
                checks++;
                if (rsp_res !== 8'(2 * rcv)) begin
                    errors++; $display("FAIL b2b_res[%0d] got %0d exp %0d", rcv, rsp_res, 2 * rcv);
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            if (sent < 16) begin
                req_valid = 1'b1; req_op1 = 8'(sent); req_op2 = 8'(sent);
                if (!req_ready) drop = 1'b1;
                else sent++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got 1 exp 0"); end
        checks++; if (rcv != 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", rcv); end
        checks++; if (last - first != 15) begin errors++; $display("FAIL b2b_spacing got %0d exp 15", last - first); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        int acc = 0;
        int rcv = 0;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            req_valid = 1'b1; req_op1 = 8'(acc + 1); req_op2 = 8'd3;
            if (req_ready) begin exp_q.push_back(8'(acc + 4)); acc++; end
            @(negedge clk);
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepted got %0d exp 8", acc); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_res !== 8'd4) begin
            errors++; $display("FAIL bp_head got %0b/%0d exp 1/4", rsp_valid, rsp_res);
        end
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && rcv < 12; cyc++) begin
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got %0d exp none", rsp_res);
                end else if (rsp_res !== exp_q[0]) begin
                    errors++; $display("FAIL bp_res[%0d] got %0d exp %0d", rcv, rsp_res, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rcv++;
            end
            if (acc < 12) begin
                req_valid = 1'b1; req_op1 = 8'(acc + 1); req_op2 = 8'd3;
                if (req_ready) begin exp_q.push_back(8'(acc + 4)); acc++; end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (rcv != 12) begin errors++; $display("FAIL bp_received got %0d exp 12", rcv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost got %0d exp 0", exp_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %0b exp 0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int acc = 0;
        int rcv = 0;
        bit over = 1'b0;
        for (int cyc = 0; cyc < 300 && rcv < 20; cyc++) begin
            rsp_ready = (cyc % 2 == 0);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_res !== 8'(4 * rcv)) begin
                    errors++; $display("FAIL wrap_res[%0d] got %0d exp %0d", rcv, rsp_res, 4 * rcv);
                end
                rcv++;
            end
            if (acc < 20) begin
                req_valid = 1'b1; req_op1 = 8'(3 * acc); req_op2 = 8'(acc);
                if (req_ready) acc++;
            end else begin
                req_valid = 1'b0;
            end
            if (acc - rcv > 8) over = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (rcv != 20) begin errors++; $display("FAIL wrap_received got %0d exp 20", rcv); end
        checks++; if (over !== 1'b0) begin errors++; $display("FAIL wrap_outstanding got >8 exp <=8"); end
    endtask

    task automatic test_overflow();
        bit seen = 1'b0;
        rsp_ready = 1'b0; req_valid = 1'b1; req_op1 = 8'd200; req_op2 = 8'd100;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL ovf_timeout got no rsp exp rsp"); end
        checks++; if (rsp_res !== 8'd44) begin errors++; $display("FAIL ovf_res got %0d exp 44", rsp_res); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_pop got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        bit stale = 1'b0;
        bit seen = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op1 = 8'(i + 10); req_op2 = 8'd1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_pre got %0b/%0b exp 1/1", rsp_valid, busy);
        end
        rst = 1'b0;
        #1;
        checks++; if (pipe_valid !== 1'b0) begin errors++; $display("FAIL mid_pipe_valid got %0b exp 0", pipe_valid); end
        checks++; if (pipe_op1 !== 8'd0 || pipe_op2 !== 8'd0) begin
            errors++; $display("FAIL mid_pipe_ops got %0d/%0d exp 0/0", pipe_op1, pipe_op2);
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %0b exp 0", rsp_valid); end
        checks++; if (rsp_res !== 8'd0) begin errors++; $display("FAIL mid_rsp_res got %0d exp 0", rsp_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (rsp_valid !== 1'b0) stale = 1'b1;
            @(negedge clk);
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale got 1 exp 0"); end
        req_valid = 1'b1; req_op1 = 8'd1; req_op2 = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_timeout got no rsp exp rsp"); end
        checks++; if (rsp_res !== 8'd2) begin errors++; $display("FAIL mid_res got %0d exp 2", rsp_res); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %0b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
